// File: rtl/lcd_cmd_arbiter.sv
// Arbitrates two {RS,DATA} word streams onto one LCD controller, holding grant for a whole transaction.
// Per word: 1 accept cycle, start held until done, then DLY_CYCLES of settling; READY is the only backpressure.
module lcd_cmd_arbiter #(
   parameter int DLY_CYCLES = 262142,
   parameter int DLY_W      = 18
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iREQ0_VALID,
   input  logic [8:0] iREQ0_DATA,
   input  logic       iREQ0_LAST,
   output logic       oREQ0_READY,
   input  logic       iREQ1_VALID,
   input  logic [8:0] iREQ1_DATA,
   input  logic       iREQ1_LAST,
   output logic       oREQ1_READY,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE,
   output logic [1:0] oGRANT,
   output logic       oBUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_START,
      S_DELAY
   } state_t;

   localparam logic [DLY_W-1:0] LP_CNT_LAST = DLY_W'(DLY_CYCLES - 1);

   state_t           r_state;
   logic             r_ptr;
   logic [1:0]       r_grant;
   logic [DLY_W-1:0] r_cnt;
   logic             r_last;
   logic [7:0]       r_lcd_data;
   logic             r_lcd_rs;
   logic             r_lcd_start;

   logic             w_sel_vld;
   logic [8:0]       w_sel_dat;
   logic             w_sel_last;

   // Grant is one-hot, so bit 1 alone selects the owner's channel.
   assign w_sel_vld  = r_grant[1] ? iREQ1_VALID : iREQ0_VALID;
   assign w_sel_dat  = r_grant[1] ? iREQ1_DATA  : iREQ0_DATA;
   assign w_sel_last = r_grant[1] ? iREQ1_LAST  : iREQ0_LAST;

   assign oREQ0_READY = (r_state == S_ACCEPT) && r_grant[0];
   assign oREQ1_READY = (r_state == S_ACCEPT) && r_grant[1];
   assign oBUSY       = (r_state != S_IDLE);
   assign oGRANT      = r_grant;
   assign oLCD_DATA   = r_lcd_data;
   assign oLCD_RS     = r_lcd_rs;
   assign oLCD_START  = r_lcd_start;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state     <= S_IDLE;
         r_ptr       <= 1'b0;
         r_grant     <= 2'b00;
         r_cnt       <= '0;
         r_last      <= 1'b0;
         r_lcd_data  <= 8'h00;
         r_lcd_rs    <= 1'b0;
         r_lcd_start <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iREQ0_VALID && iREQ1_VALID) begin
                  r_grant <= r_ptr ? 2'b10 : 2'b01;
                  r_state <= S_ACCEPT;
               end else if (iREQ0_VALID) begin
                  r_grant <= 2'b01;
                  r_state <= S_ACCEPT;
               end else if (iREQ1_VALID) begin
                  r_grant <= 2'b10;
                  r_state <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (w_sel_vld) begin
                  r_lcd_rs    <= w_sel_dat[8];
                  r_lcd_data  <= w_sel_dat[7:0];
                  r_last      <= w_sel_last;
                  r_lcd_start <= 1'b1;
                  r_state     <= S_START;
               end
            end
            S_START: begin
               if (iLCD_DONE) begin
                  r_lcd_start <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (r_cnt == LP_CNT_LAST) begin
                  if (r_last) begin
                     // Next contention goes to whoever did not just own the bus.
                     r_ptr   <= r_grant[0];
                     r_grant <= 2'b00;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_ACCEPT;
                  end
               end else begin
                  r_cnt <= r_cnt + DLY_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Shares the single character-LCD bus controller between two independent text sources, such as a status writer and a message writer. Each source pushes 9-bit LCD words, {RS, DATA[7:0]}, over a valid/ready handshake. Grant is held for a whole transaction, from the first word through the word flagged last, so strings from the two sources never interleave. For each accepted word the block drives the controller's start/done handshake, then enforces a fixed settling delay before taking the next word.

## Interface
Parameters:
- DLY_CYCLES, default 262142: post-done settling delay in clocks; legal range 1..2^DLY_W-1.
- DLY_W, default 18: delay counter width.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset; one clock; reset is synchronous and active-high
- iREQ0_VALID  in  1  requester 0 has a word
- iREQ0_DATA  in  9  requester 0 word, bit 8 = RS, bits 7:0 = data
- iREQ0_LAST  in  1  word is the final word of requester 0's transaction
- oREQ0_READY  out  1  requester 0 word accepted this cycle when VALID is also high
- iREQ1_VALID, iREQ1_DATA[8:0], iREQ1_LAST, oREQ1_READY: same meanings for requester 1
- oLCD_DATA  out  8  data to the LCD controller
- oLCD_RS  out  1  register select to the LCD controller
- oLCD_START  out  1  controller start request, level-held until done
- iLCD_DONE  in  1  controller completion pulse
- oGRANT  out  2  one-hot current owner; 00 when no requester holds the bus
- oBUSY  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: no grant. If either VALID is high, grant the winner and go to ACCEPT.
    - Only one VALID high: that requester wins.
    - Both VALID high: the requester indicated by the round-robin pointer PTR wins.
  - ACCEPT: oREQg_READY = 1 for the granted requester only; the other READY stays 0.
    - On VALID_g & READY_g: register DATA into oLCD_RS/oLCD_DATA, register LAST into last_q, set oLCD_START = 1, go to START.
    - If VALID_g is low, stay in ACCEPT. The grant is held indefinitely; there is no timeout.
  - START: hold oLCD_START, oLCD_DATA and oLCD_RS stable. When iLCD_DONE is high: clear oLCD_START, clear the counter, go to DELAY.
  - DELAY: increment the counter each cycle. When counter == DLY_CYCLES-1:
    - If last_q = 1: release the grant (oGRANT = 00), set PTR to the other requester, go to IDLE.
    - If last_q = 0: go to ACCEPT with the grant unchanged.
- READY is combinational from state and grant only. It never depends on the same cycle's VALID.
- iLCD_DONE is ignored outside START.
- Counter arithmetic is unsigned, DLY_W bits wide, and never wraps because DLY_CYCLES ≤ 2^DLY_W-1.
- Reset values:
  - state = IDLE, PTR = requester 0.
  - oGRANT = 00, oBUSY = 0, oREQ0_READY = oREQ1_READY = 0.
  - oLCD_START = 0, oLCD_DATA = 0, oLCD_RS = 0.
  - Counter = 0, last_q = 0.
- Reset mid-transaction:
  - Takes effect at the next iCLK edge and aborts any word in flight.
  - oLCD_START drops and the grant is released.
  - The aborted word is not re-sent.

## Timing
- IDLE to ACCEPT: 1 cycle. READY is first visible on the cycle after VALID is sampled in IDLE.
- Handshake to start: oLCD_START rises on the edge that completes the handshake; oLCD_DATA and oLCD_RS are valid in the same cycle.
- START exit: iLCD_DONE is sampled every cycle in START, including the first. oLCD_START is low on the cycle after done is sampled.
- DELAY length: exactly DLY_CYCLES cycles.
- Minimum word period with back-to-back VALID: 1 (ACCEPT) + N_done (START, N_done ≥ 1) + DLY_CYCLES.
- Handover gap: after a last word, requester switching costs 1 extra IDLE cycle. Both oGRANT bits are never high in the same cycle.
- Fairness: a requester that keeps VALID high continuously gets the bus within one foreign transaction.

## Test plan
All scenarios use DLY_CYCLES=4, DLY_W=3, and a controller model that pulses done 3 cycles after start.
- Single word: requester 0 sends 0x141 with LAST → oLCD_DATA=0x41, oLCD_RS=1, oLCD_START high for 3 cycles; DELAY lasts 4 cycles; oGRANT returns to 00; PTR = requester 1.
- Transaction lock: requester 0 sends 3 words (LAST on the third) while requester 1 holds VALID throughout → oREQ1_READY stays 0 until requester 0's third DELAY completes; requester 1's first word is accepted 2 cycles later.
- Simultaneous request: both VALID high in IDLE after reset → requester 0 wins. After its LAST word, both VALID high again → requester 1 wins.
- Stalled owner: the granted requester drops VALID for 10 cycles mid-transaction → state stays in ACCEPT, grant is held, the other requester is never served; oLCD_START stays low.
- Stray done: iLCD_DONE pulsed in IDLE and in DELAY → no state change and the delay count is unaffected.
- Reset abort: iRST asserted for 1 cycle during START → on the next cycle oLCD_START=0, oGRANT=00, oBUSY=0, oLCD_DATA=0; the next request is arbitrated from PTR=requester 0.
